// File: rtl/md_unit.sv
// EX-stage multiply/divide unit for the 5-stage MIPS pipeline.
// Fixed-latency mult/div results land in architectural HI/LO; mfhi/mflo read them combinationally.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    input  logic        Start,
    input  logic        Flush,
    output logic        Busy,
    output logic [31:0] Out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic             r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_accept;
    logic             w_is_mult;
    logic             w_is_div;
    logic [63:0]      w_res;

    // Results are packed as {HI, LO}.
    function automatic logic [63:0] f_mul_s(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    function automatic logic [63:0] f_mul_u(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua;
        logic [63:0] ub;
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    function automatic logic [63:0] f_divu(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0)
            return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    // Sign-magnitude division: 0x80000000 / -1 wraps naturally to quotient 0x80000000, remainder 0.
    function automatic logic [63:0] f_divs(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] uq;
        logic [31:0] ur;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0)
            return {a, 32'hFFFF_FFFF};
        ua = a[31] ? (~a + 32'd1) : a;
        ub = b[31] ? (~b + 32'd1) : b;
        uq = ua / ub;
        ur = ua % ub;
        q  = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
        r  = a[31] ? (~ur + 32'd1) : ur;
        return {r, q};
    endfunction

    assign w_accept  = Start && !Flush && (r_state == ST_IDLE);
    assign w_is_mult = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
    assign w_is_div  = (MDOp == OP_DIV)  || (MDOp == OP_DIVU);

    always_comb begin
        w_res = 64'd0;
        case (r_op)
            OP_MULT:  w_res = f_mul_s(r_a, r_b);
            OP_MULTU: w_res = f_mul_u(r_a, r_b);
            OP_DIV:   w_res = f_divs(r_a, r_b);
            OP_DIVU:  w_res = f_divu(r_a, r_b);
            default:  w_res = 64'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else if (r_state == ST_IDLE) begin
            if (w_accept) begin
                if (w_is_mult) begin
                    r_op    <= MDOp;
                    r_cnt   <= CNT_W'(MULT_CYCLES - 1);
                    r_state <= ST_RUN;
                end else if (w_is_div) begin
                    r_op    <= MDOp;
                    r_cnt   <= CNT_W'(DIV_CYCLES - 1);
                    r_state <= ST_RUN;
                end else if (MDOp == OP_MTHI) begin
                    r_hi <= A;
                end else if (MDOp == OP_MTLO) begin
                    r_lo <= A;
                end
            end
        end else begin
            // Flush and Start are deliberately ignored here: an issued op always retires.
            if (r_cnt == '0) begin
                r_hi    <= w_res[63:32];
                r_lo    <= w_res[31:0];
                r_state <= ST_IDLE;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Operand latches carry data only, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_accept && (w_is_mult || w_is_div)) begin
            r_a <= A;
            r_b <= B;
        end
    end

    always_comb begin
        Out = 32'd0;
        case (MDOp)
            OP_MFHI: Out = r_hi;
            OP_MFLO: Out = r_lo;
            default: Out = 32'd0;
        endcase
    end

    assign Busy = (r_state == ST_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: long ops push expected HI/LO and Busy length,
// a negedge monitor pops and compares when Busy falls.
module tb_md_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDOp;
    logic        Start;
    logic        Flush;
    logic        Busy;
    logic [31:0] Out;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        int          id;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   busy_cnt = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .MDOp(MDOp),
        .Start(Start), .Flush(Flush), .Busy(Busy), .Out(Out), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op for a single cycle; long ops get an expectation queued.
    task automatic issue(input int id, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input int cyc);
        exp_t e;
        if (cyc > 0) begin
            e.id = id; e.hi = ehi; e.lo = elo; e.cyc = cyc;
            sbq.push_back(e);
        end
        MDOp = op; A = a; B = b; Start = 1'b1;
        tick();
        Start = 1'b0; MDOp = 4'd0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (Busy && k < 200) begin
            tick();
            k++;
        end
        chk("idle_wait", {31'd0, Busy}, 32'd0);
        @(negedge clk);
        #1;
    endtask

    // Monitor: result presented on the cycle Busy drops.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
            end else if (Busy) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("op%0d_hi", e.id), HI, e.hi);
                    chk($sformatf("op%0d_lo", e.id), LO, e.lo);
                    chk($sformatf("op%0d_busy_len", e.id), 32'(busy_cnt), 32'(e.cyc));
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        rst_n = 1'b0; A = 32'd0; B = 32'd0; MDOp = 4'd0; Start = 1'b0; Flush = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_out", Out, 32'd0);

        issue(1, 4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        chk("mult_busy_next", {31'd0, Busy}, 32'd1);
        wait_idle();
        issue(2, 4'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5);
        wait_idle();

        issue(3, 4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        wait_idle();
        issue(4, 4'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10);
        wait_idle();
        issue(5, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
        wait_idle();
        issue(6, 4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        wait_idle();
        issue(7, 4'd3, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 10);
        wait_idle();
        issue(8, 4'd4, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 10);
        wait_idle();

        Flush = 1'b1;
        issue(9, 4'd5, 32'h0000_DEAD, 32'd0, 32'd0, 32'd0, 0);
        Flush = 1'b0;
        chk("flush_mthi_hi", HI, 32'h1234_5678);
        chk("flush_mthi_busy", {31'd0, Busy}, 32'd0);

        issue(10, 4'd5, 32'hCAFE_0001, 32'd0, 32'd0, 32'd0, 0);
        chk("mthi_hi", HI, 32'hCAFE_0001);
        chk("mthi_busy", {31'd0, Busy}, 32'd0);

        issue(11, 4'd1, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 5);
        tick();
        MDOp = 4'd6; A = 32'd5; Start = 1'b1;
        tick();
        Start = 1'b0; MDOp = 4'd0;
        chk("ign_start_lo", LO, 32'hFFFF_FFFF);
        wait_idle();
        chk("ign_start_after_lo", LO, 32'd0);

        issue(12, 4'd1, 32'd7, 32'd6, 32'd0, 32'd42, 5);
        tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        wait_idle();

        issue(13, 4'd6, 32'h0000_0055, 32'd0, 32'd0, 32'd0, 0);
        MDOp = 4'd8;
        #1;
        chk("mflo_out", Out, 32'h0000_0055);
        MDOp = 4'd7;
        #1;
        chk("mfhi_out", Out, 32'd0);
        MDOp = 4'd0;
        #1;
        chk("none_out", Out, 32'd0);
        MDOp = 4'd9;
        #1;
        chk("op9_out", Out, 32'd0);
        MDOp = 4'd0;

        issue(14, 4'd5, 32'h0BAD_F00D, 32'd0, 32'd0, 32'd0, 0);
        issue(15, 4'd3, 32'd1000, 32'd3, 32'd0, 32'd0, 0);
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, Busy}, 32'd0);
        chk("arst_hi", HI, 32'd0);
        chk("arst_lo", LO, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        MDOp = 4'd7;
        #1;
        chk("arst_mfhi", Out, 32'd0);
        MDOp = 4'd0;
        tick(); tick();
        chk("arst_stays_idle", {31'd0, Busy}, 32'd0);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It sits beside the integer ALU and consumes the same forwarded operand buses A/B.
- Executes mult, multu, div, divu, mthi and mtlo into architectural HI/LO registers.
- Provides mfhi/mflo read data on Out, which the EX result mux selects alongside the ALU result.
- Busy drives the hazard unit, which stalls any MD instruction in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (>=1)
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- A  in  32  operand rs (forwarded)
- B  in  32  operand rt (forwarded)
- MDOp  in  4  0=none 1=mult 2=multu 3=div 4=divu 5=mthi 6=mtlo 7=mfhi 8=mflo; others=none
- Start  in  1  one-cycle pulse: EX holds a valid MD write instruction (MDOp 1..6)
- Flush  in  1  EX instruction cancelled by exception/interrupt this cycle
- Busy  out  1  operation in flight
- Out  out  32  MDOp 7 -> HI; MDOp 8 -> LO; otherwise 0
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register

Behaviour:
- Reset: asynchronous, active-low. Clock is clk; reset is rst_n. Asserting rst_n=0 clears HI, LO and the counter, and sets state to IDLE and Busy=0 immediately, including mid-operation; the in-flight result is discarded.
- Issue: an op is accepted when Start=1 && Flush=0 && state IDLE. Flush=1 in the same cycle suppresses it entirely: no state, HI or LO change.
- Ignored Start: Start while Busy=1 is ignored, with HI/LO and the in-flight op unaffected. The hazard unit prevents this; the bench checks it anyway.
- mthi/mtlo: on the accepting edge, HI<=A (mthi) or LO<=A (mtlo). No busy period.
- mult/multu/div/divu: on the accepting edge, A, B and the op are latched, cnt<=MULT_CYCLES-1 or DIV_CYCLES-1, and state becomes RUN. Busy=1 from the following cycle.
- RUN state:
  - Each edge decrements cnt.
  - On the edge where cnt==0, HI/LO are written, state returns to IDLE, and Busy falls on that same edge.
  - Busy is therefore high for exactly N cycles, and the new HI/LO are visible in cycle N+1 after issue.
- Flush during RUN has no effect: an issued op always completes, matching MIPS semantics where the MD op retired before the exception.
- Results, computed from the latched operands only:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - divu: LO = A/B, HI = A%B (unsigned).
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Divide by zero (div and divu): LO=32'hFFFFFFFF, HI=A. No exception is raised.
- Signed overflow (div 0x80000000 by 0xFFFFFFFF): LO=0x80000000, HI=0.
- Out: purely combinational from MDOp and the current HI/LO registers. It never bypasses an in-flight result; the hazard unit stalls mfhi/mflo while Busy.
- Counter width: clog2(max(MULT_CYCLES,DIV_CYCLES))+1. The latency is not operand-dependent.

Test Plan:
- Reset: drive rst_n=0 mid-RUN of a div → Busy=0, HI=LO=0 in the same cycle (asynchronous); an mfhi issued after release reads 0.
- mult A=0xFFFFFFFE(-2), B=3 → Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu same operands → HI=0x2, LO=0xFFFFFFFA.
- div A=-7(0xFFFFFFF9), B=2 → Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div overflow: div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- divu A=0x12345678, B=0 → LO=0xFFFFFFFF, HI=0x12345678; no other signal changes.
- Start+Flush: Start+Flush with mthi A=0xDEAD → HI unchanged.
- Start while Busy: a second Start (mtlo 5) during Busy → ignored; mult result lands unaltered.
- Flush mid-RUN: assert Flush during RUN → result still written at cycle N.
- Read ports: mtlo 0x55 then MDOp=8 → Out=0x55 the next cycle. MDOp=0 → Out=0.
